// File: rtl/sram_like_slave_if.sv
// Master-side request/response bus of the SRAM-like slave.
// Clock and reset travel as plain ports next to this interface.
interface sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_slave.sv
// SRAM-like bus slave in front of a synchronous RAM: accepts up to DEPTH
// outstanding requests and answers each in order exactly DATA_LAT cycles later.
module sram_like_slave #(
    parameter int DEPTH    = 2,
    parameter int ADDR_LAT = 0,
    parameter int DATA_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    sram_like_slave_if.slave     bus,
    output logic                 o_ram_en,
    output logic [3:0]           o_ram_we,
    output logic [31:0]          o_ram_addr,
    output logic [31:0]          o_ram_wdata,
    input  logic [31:0]          i_ram_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [3:0]       ADDR_LAT_C = 4'(ADDR_LAT);
    localparam logic [3:0]       DATA_LAT_C = 4'(DATA_LAT);
    localparam logic [OCC_W-1:0] DEPTH_C    = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [3:0]       r_waitCnt;
    logic [OCC_W-1:0] r_occ;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_isWr;
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_age  [DEPTH];
    logic             r_capPending;
    logic [PTR_W-1:0] r_capPtr;

    logic             w_accept;
    logic             w_pop;
    logic             w_unused;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Both handshakes are gated by reset so the bus goes quiet the moment
    // reset asserts, without waiting for a clock edge.
    assign w_accept = i_resetn && bus.req && (r_waitCnt >= ADDR_LAT_C) && (r_occ < DEPTH_C);
    assign w_pop    = i_resetn && r_valid[r_rdPtr] && (r_age[r_rdPtr] == DATA_LAT_C);

    assign w_unused = &{1'b0, bus.size, bus.addr[1:0]};

    always_comb begin
        bus.addr_ok = w_accept;
        bus.data_ok = w_pop;
        bus.rdata   = w_pop ? r_data[r_rdPtr] : 32'h0;
        o_ram_en    = w_accept;
        o_ram_we    = (w_accept && bus.wr) ? bus.wstrb : 4'h0;
        o_ram_addr  = {bus.addr[31:2], 2'b00};
        o_ram_wdata = bus.wdata;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_waitCnt <= '0;
        end else if (!bus.req || w_accept) begin
            r_waitCnt <= '0;
        end else if (r_waitCnt != 4'hF) begin
            r_waitCnt <= r_waitCnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_occ        <= '0;
            r_capPending <= 1'b0;
            r_capPtr     <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            r_capPending <= w_accept && !bus.wr;
            r_capPtr     <= r_wrPtr;
        end
    end

    // The accept cycle itself is age 0, so a freshly pushed entry already
    // holds age 1; read data lands one cycle later, well before the pop.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_valid <= '0;
            r_isWr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && (r_wrPtr == PTR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_isWr[i]  <= bus.wr;
                    r_data[i]  <= '0;
                    r_age[i]   <= 4'd1;
                end else begin
                    if (w_pop && (r_rdPtr == PTR_W'(i))) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (r_valid[i] && (r_age[i] != DATA_LAT_C)) begin
                        r_age[i] <= r_age[i] + 4'd1;
                    end
                    if (r_capPending && (r_capPtr == PTR_W'(i)) && !r_isWr[i]) begin
                        r_data[i] <= i_ram_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sram_like_slave.md
SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 Parameter DEPTH, default 2, maximum accepted-but-unanswered requests; legal range 1..8.
REQ-002 Parameter ADDR_LAT, default 0, minimum cycles `req` must be held high before `addr_ok` may rise; legal range 0..15.
REQ-003 Parameter DATA_LAT, default 2, minimum cycles from accept to `data_ok` for that request; legal range 2..15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 req  in  1  master request valid.
REQ-007 wr  in  1  1 = write, 0 = read.
REQ-008 size  in  2  access size (0 = byte, 1 = half, 2 = word); informational only.
REQ-009 wstrb  in  4  byte enables for writes.
REQ-010 addr  in  32  byte address.
REQ-011 wdata  in  32  write data.
REQ-012 addr_ok  out  1  request accepted this cycle when `req` && `addr_ok`.
REQ-013 data_ok  out  1  one-cycle response pulse; in request order.
REQ-014 rdata  out  32  read data, valid while `data_ok` is high.
REQ-015 ram_en  out  1  synchronous RAM access enable.
REQ-016 ram_we  out  4  synchronous RAM byte write enables.
REQ-017 ram_addr  out  32  RAM byte address with bits [1:0] forced to 0.
REQ-018 ram_wdata  out  32  RAM write data.
REQ-019 ram_rdata  in  32  RAM read data, valid one cycle after `ram_en`.

Function
REQ-020 `addr_ok` SHALL be high iff all of the following hold:
- `req` = 1;
- the registered wait counter ≥ ADDR_LAT;
- the registered occupancy < DEPTH.

A `data_ok` in the same cycle SHALL NOT relieve the full condition.

REQ-021 Wait counter:
- increments (saturating at 15) each cycle `req` is high without accept;
- clears on accept and whenever `req` is low.

REQ-022 On accept, in the same cycle (combinationally):
- `ram_en` = 1;
- `ram_we` = `wr` ? `wstrb` : 0;
- `ram_addr` = {`addr`[31:2], 2'b00};
- `ram_wdata` = `wdata`.

When no request is accepted, `ram_en` = 0 and `ram_we` = 0.

REQ-023 Each accept SHALL push one FIFO entry holding {`wr`, data, age counter}.
- The entry's data SHALL be captured from `ram_rdata` one cycle after accept for reads.
- The entry's data SHALL be 0 for writes.

REQ-024 Age counter: starts at 0 on accept and increments each cycle, saturating at DATA_LAT.

REQ-025 `data_ok` SHALL be high iff the FIFO head is valid and its age equals DATA_LAT.
- On `data_ok` the head pops; at most one pop per cycle.
- Responses are strictly in accept order.

REQ-026 `rdata` SHALL present the head entry's data when `data_ok` = 1, and 0 otherwise.

REQ-027 Occupancy update per cycle:
- +1 on accept only;
- −1 on pop only;
- unchanged on simultaneous accept and pop.

REQ-028 The FIFO read and write pointers SHALL wrap modulo DEPTH without losing or duplicating entries.

REQ-029 Back-to-back accepts (one per cycle) SHALL be supported while occupancy < DEPTH.

REQ-030 The master has no backpressure on responses: `data_ok` SHALL never be held waiting on any input.

Reset
REQ-031 While `resetn` = 0, regardless of `clk`:
- `addr_ok`, `data_ok`, `ram_en` SHALL be 0;
- `ram_we` SHALL be 4'h0;
- `rdata` SHALL be 0;
- occupancy, pointers, and wait counter SHALL be cleared.

REQ-032 Requests outstanding when reset asserts SHALL be discarded; no `data_ok` is issued for them after reset release.

REQ-033 The first accept SHALL be possible in the first rising edge after `resetn` deasserts, subject to ADDR_LAT.

Verification
REQ-034 Defaults; RAM word 0x100 = 0x12345678; read req at cycle 0:
- `addr_ok` in cycle 0;
- `ram_en` = 1 with `ram_addr` = 0x100;
- `data_ok` in cycle 2 with `rdata` = 0x12345678.

REQ-035 Write of `wdata` 0xAABBCCDD, `wstrb` 4'b0011 to 0x104:
- `ram_we` = 4'b0011;
- `data_ok` two cycles later with `rdata` = 0;
- a subsequent read of 0x104 returns 0x0000CCDD when the RAM previously held 0.

REQ-036 DEPTH = 2, `req` held for 4 reads:
- `addr_ok` is high at most 2 consecutive cycles;
- it reasserts only the cycle after a `data_ok`;
- exactly 4 `data_ok` pulses are issued, in order, with correct data.

REQ-037 ADDR_LAT = 3, `req` raised at cycle 0 and held: `addr_ok` is first high in cycle 3, not earlier.

REQ-038 Reset cases:
- Assert `resetn` = 0 mid-flight with 2 outstanding: all outputs are 0 immediately (asynchronously); no `data_ok` for those requests after release.
- A new read after release completes normally.
